reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised register file for the 5-stage MIPS pipeline: two combinational read ports for decode, one clocked write port for writeback, an optional same-cycle writeback bypass, and a per-register busy scoreboard that the hazard unit uses to stall on outstanding producers. It is the clocked, generalised successor of the current register file and sits between the ID and WB stages.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- BYPASS, 1, 1 = writeback data forwarded to same-cycle reads; 0 = reads see array only
- ZERO_REG, 1, 1 = register 0 reads zero and ignores writes/allocs

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- rd_addr1  input  ADDR_W  read port 1 address
- rd_addr2  input  ADDR_W  read port 2 address
- rd_data1  output  DATA_W  read port 1 data
- rd_data2  output  DATA_W  read port 2 data
- rd_busy1  output  1  register at rd_addr1 has an outstanding producer
- rd_busy2  output  1  register at rd_addr2 has an outstanding producer
- wb_en  input  1  writeback strobe
- wb_addr  input  ADDR_W  writeback destination
- wb_data  input  DATA_W  writeback data
- alloc_en  input  1  issue stage marks a destination busy
- alloc_addr  input  ADDR_W  destination being allocated
- busy_count  output  ADDR_W+1  number of busy registers
- dbg_addr  input  ADDR_W  debug read address
- dbg_data  output  DATA_W  debug read data (never bypassed)

## Operation
- Storage: 2**ADDR_W x DATA_W array plus 2**ADDR_W busy bits plus busy_count register.
- Write: on clk rising edge with wb_en=1, array[wb_addr] <= wb_data; skipped when ZERO_REG=1 and wb_addr=0.
- Read: combinational from array. With BYPASS=1, if wb_en=1, wb_addr=rd_addrN and address is writable, rd_dataN = wb_data and rd_busyN = 0.
- ZERO_REG=1: rd_dataN/dbg_data = 0 for address 0; busy[0] never set.
- Scoreboard per edge, for each register r:
  - set if alloc_en and alloc_addr=r (writable)
  - else clear if wb_en and wb_addr=r
  - else hold
- Simultaneous alloc and wb to same register: alloc wins, busy stays 1 (new producer supersedes); array still takes wb_data.
- Alloc to already-busy register: stays 1, no count change; single outstanding producer per register tracked (first wb clears).
- Wb to non-busy register: array written, busy unchanged.
- busy_count = popcount of busy bits, maintained incrementally: +1 on 0->1 transition, -1 on 1->0, net of both events same cycle; never exceeds 2**ADDR_W (or 2**ADDR_W-1 with ZERO_REG).
- Async reset: all array entries 0, all busy 0, busy_count 0 immediately. While rst=1: rd_data1, rd_data2, dbg_data forced 0; rd_busy1/2 forced 0; writes and allocs ignored.

## Timing
- Read latency: 0 cycles (combinational).
- Write visible via array on cycle after wb edge; visible same cycle only via bypass (BYPASS=1).
- Busy set visible on rd_busyN the cycle after alloc edge; cleared busy visible same cycle through bypass (BYPASS=1), else next cycle.
- busy_count updates on the same edge as the busy bits.
- Reset assertion takes effect without clk; deassertion is synchronised externally; first write accepted on first rising edge with rst=0.

## Test plan
- Reset: write 0xDEADBEEF to r3, assert rst mid-cycle -> rd_data1(r3)=0 immediately and after release; busy_count=0.
- Write/read: wb_en, r5<=0x12345678 -> next cycle rd_data2(r5)=0x12345678; r0 write of 0xFFFFFFFF -> rd_data1(r0)=0.
- Bypass: same cycle wb r7<=0xA5A5A5A5 and rd_addr1=7 -> rd_data1=0xA5A5A5A5 with BYPASS=1; old value with BYPASS=0.
- Scoreboard: alloc r9 -> next cycle rd_busy1=1, busy_count=1; wb r9 -> busy clears, busy_count=0.
- Collision: r9 busy; same edge alloc r9 and wb r9<=0x55 -> busy stays 1, busy_count unchanged, array r9=0x55.
- Fill: alloc r1..r31 on consecutive cycles -> busy_count=31; alloc r0 -> no change; dbg_addr sweep returns array values unbypassed.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one clocked writeback port,
// optional same-cycle writeback bypass and a per-register busy scoreboard.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic [ADDR_W:0]   busy_count,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wb_ok;
  logic              alloc_ok;
  logic              cnt_inc;
  logic              cnt_dec;
  logic              hit1;
  logic              hit2;
  logic              zero1;
  logic              zero2;
  logic              zero_dbg;

  assign wb_ok    = wb_en    && !((ZERO_REG != 0) && (wb_addr    == '0));
  assign alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wb_ok) begin
      mem[wb_addr] <= wb_data;
    end
  end

  // Alloc is applied after the wb clear so a new producer supersedes a retiring one.
  always_comb begin
    busy_nxt = busy;
    if (wb_ok)    busy_nxt[wb_addr]    = 1'b0;
    if (alloc_ok) busy_nxt[alloc_addr] = 1'b1;
  end

  assign cnt_inc = alloc_ok && !busy[alloc_addr];
  assign cnt_dec = wb_ok && busy[wb_addr] && !(alloc_ok && (alloc_addr == wb_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= busy_count + CW'(cnt_inc) - CW'(cnt_dec);
    end
  end

  assign hit1     = (BYPASS != 0) && wb_ok && (wb_addr == rd_addr1);
  assign hit2     = (BYPASS != 0) && wb_ok && (wb_addr == rd_addr2);
  assign zero1    = (ZERO_REG != 0) && (rd_addr1 == '0);
  assign zero2    = (ZERO_REG != 0) && (rd_addr2 == '0);
  assign zero_dbg = (ZERO_REG != 0) && (dbg_addr == '0);

  // Reset forces every observable read to zero, ahead of bypass and array.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    rd_busy1 = 1'b0;
    rd_busy2 = 1'b0;
    dbg_data = '0;
    if (!rst) begin
      if (hit1)        rd_data1 = wb_data;
      else if (!zero1) rd_data1 = mem[rd_addr1];
      if (hit2)        rd_data2 = wb_data;
      else if (!zero2) rd_data2 = mem[rd_addr2];
      rd_busy1 = !hit1 && busy[rd_addr1];
      rd_busy2 = !hit2 && busy[rd_addr2];
      if (!zero_dbg)   dbg_data = mem[dbg_addr];
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus random traffic
// against an array/queue-level reference model, with a BYPASS=0 twin.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rd_addr1 = '0, rd_addr2 = '0, wb_addr = '0, alloc_addr = '0, dbg_addr = '0;
  logic        wb_en = 1'b0, alloc_en = 1'b0;
  logic [31:0] wb_data = '0;

  logic [31:0] rd_data1, rd_data2, dbg_data;
  logic        rd_busy1, rd_busy2;
  logic [5:0]  busy_count;
  logic [31:0] nb_rd_data1, nb_rd_data2, nb_dbg_data;
  logic        nb_rd_busy1, nb_rd_busy2;
  logic [5:0]  nb_busy_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .busy_count(busy_count),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(nb_rd_data1), .rd_data2(nb_rd_data2),
    .rd_busy1(nb_rd_busy1), .rd_busy2(nb_rd_busy2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .busy_count(nb_busy_count),
    .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data)
  );

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  // One clock edge of the architectural model: r0 is never written or marked.
  function automatic void model_edge();
    if (wb_en && wb_addr != 0) begin
      m_mem[wb_addr]  = wb_data;
      m_busy[wb_addr] = 1'b0;
    end
    if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && wb_en && wb_addr == a) return wb_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_bz(input logic [4:0] a, input bit byp);
    if (byp && wb_en && wb_addr == a && a != 0) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [5:0] exp_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return 6'(n);
  endfunction

  task automatic set_idle();
    wb_en = 1'b0; alloc_en = 1'b0; wb_addr = '0; alloc_addr = '0; wb_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rd_addr1 = 5'd3;
    #1 rst = 1'b1;
    #1;
    total++; if (rd_data1 !== 32'h0) begin bad++; $display("[TB] FAIL reset_rd1 got=%h exp=%h", rd_data1, 32'h0); end
    total++; if (busy_count !== 6'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", busy_count); end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
    alloc_en = 1'b1; alloc_addr = 5'd6;
    tick();
    set_idle();
    #1;
    total++; if (rd_data1 !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL pre_reset_r3 got=%h exp=%h", rd_data1, 32'hDEADBEEF); end
    total++; if (busy_count !== 6'd1) begin bad++; $display("[TB] FAIL pre_reset_count got=%0d exp=1", busy_count); end
    rst = 1'b1;
    #1;
    total++; if (rd_data1 !== 32'h0) begin bad++; $display("[TB] FAIL reset_async_r3 got=%h exp=0", rd_data1); end
    total++; if (busy_count !== 6'd0) begin bad++; $display("[TB] FAIL reset_async_count got=%0d exp=0", busy_count); end
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h1111_1111;
    alloc_en = 1'b1; alloc_addr = 5'd4; rd_addr2 = 5'd4;
    #1;
    total++; if (rd_data2 !== 32'h0) begin bad++; $display("[TB] FAIL reset_bypass_forced got=%h exp=0", rd_data2); end
    tick();
    rst = 1'b0;
    model_clear();
    set_idle();
    #1;
    total++; if (rd_data1 !== 32'h0) begin bad++; $display("[TB] FAIL post_reset_r3 got=%h exp=0", rd_data1); end
    total++; if (rd_data2 !== 32'h0) begin bad++; $display("[TB] FAIL ignored_write_r4 got=%h exp=0", rd_data2); end
    total++; if (rd_busy2 !== 1'b0) begin bad++; $display("[TB] FAIL ignored_alloc_r4 got=%b exp=0", rd_busy2); end
    total++; if (busy_count !== 6'd0) begin bad++; $display("[TB] FAIL post_reset_count got=%0d exp=0", busy_count); end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h12345678;
    tick();
    wb_addr = 5'd0; wb_data = 32'hFFFFFFFF; rd_addr2 = 5'd5; rd_addr1 = 5'd0;
    #1;
    total++; if (rd_data2 !== 32'h12345678) begin bad++; $display("[TB] FAIL write_r5 got=%h exp=%h", rd_data2, 32'h12345678); end
    total++; if (rd_data1 !== 32'h0) begin bad++; $display("[TB] FAIL r0_bypass got=%h exp=0", rd_data1); end
    tick();
    set_idle();
    #1;
    total++; if (rd_data1 !== 32'h0) begin bad++; $display("[TB] FAIL r0_write got=%h exp=0", rd_data1); end
    @(negedge clk);
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0BAD_F00D;
    tick();
    wb_data = 32'hA5A5A5A5; rd_addr1 = 5'd7;
    #1;
    total++; if (rd_data1 !== 32'hA5A5A5A5) begin bad++; $display("[TB] FAIL bypass_on got=%h exp=%h", rd_data1, 32'hA5A5A5A5); end
    total++; if (nb_rd_data1 !== 32'h0BAD_F00D) begin bad++; $display("[TB] FAIL bypass_off got=%h exp=%h", nb_rd_data1, 32'h0BAD_F00D); end
    tick();
    set_idle();
    #1;
    total++; if (nb_rd_data1 !== 32'hA5A5A5A5) begin bad++; $display("[TB] FAIL bypass_off_next got=%h exp=%h", nb_rd_data1, 32'hA5A5A5A5); end
  endtask

  task automatic test_scoreboard();
    alloc_en = 1'b1; alloc_addr = 5'd9; rd_addr1 = 5'd9;
    #1;
    total++; if (rd_busy1 !== 1'b0) begin bad++; $display("[TB] FAIL alloc_same_cycle got=%b exp=0", rd_busy1); end
    tick();
    set_idle();
    #1;
    total++; if (rd_busy1 !== 1'b1) begin bad++; $display("[TB] FAIL alloc_busy got=%b exp=1", rd_busy1); end
    total++; if (busy_count !== 6'd1) begin bad++; $display("[TB] FAIL alloc_count got=%0d exp=1", busy_count); end
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    #1;
    total++; if (rd_busy1 !== 1'b0) begin bad++; $display("[TB] FAIL wb_bypass_busy got=%b exp=0", rd_busy1); end
    total++; if (nb_rd_busy1 !== 1'b1) begin bad++; $display("[TB] FAIL wb_nobypass_busy got=%b exp=1", nb_rd_busy1); end
    tick();
    set_idle();
    #1;
    total++; if (rd_busy1 !== 1'b0) begin bad++; $display("[TB] FAIL wb_cleared got=%b exp=0", rd_busy1); end
    total++; if (busy_count !== 6'd0) begin bad++; $display("[TB] FAIL wb_count got=%0d exp=0", busy_count); end
    @(negedge clk);
  endtask

  task automatic test_collision();
    alloc_en = 1'b1; alloc_addr = 5'd9;
    tick();
    alloc_addr = 5'd9; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
    tick();
    alloc_en = 1'b1; alloc_addr = 5'd9;
    tick();
    set_idle();
    rd_addr1 = 5'd9;
    #1;
    total++; if (rd_busy1 !== 1'b1) begin bad++; $display("[TB] FAIL collision_busy got=%b exp=1", rd_busy1); end
    total++; if (busy_count !== 6'd1) begin bad++; $display("[TB] FAIL collision_count got=%0d exp=1", busy_count); end
    total++; if (rd_data1 !== 32'h55) begin bad++; $display("[TB] FAIL collision_data got=%h exp=%h", rd_data1, 32'h55); end
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h12;
    tick();
    set_idle();
    #1;
    total++; if (busy_count !== 6'd1) begin bad++; $display("[TB] FAIL wb_nonbusy_count got=%0d exp=1", busy_count); end
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int r = 1; r < 32; r++) begin
      alloc_en = 1'b1; alloc_addr = 5'(r);
      tick();
    end
    set_idle();
    #1;
    total++; if (busy_count !== 6'd31) begin bad++; $display("[TB] FAIL fill_count got=%0d exp=31", busy_count); end
    alloc_en = 1'b1; alloc_addr = 5'd0; rd_addr2 = 5'd0;
    tick();
    set_idle();
    #1;
    total++; if (busy_count !== 6'd31) begin bad++; $display("[TB] FAIL alloc_r0_count got=%0d exp=31", busy_count); end
    total++; if (rd_busy2 !== 1'b0) begin bad++; $display("[TB] FAIL alloc_r0_busy got=%b exp=0", rd_busy2); end
    for (int r = 0; r < 32; r++) begin
      dbg_addr = 5'(r);
      wb_en = 1'b1; wb_addr = 5'(r); wb_data = $urandom;
      #1;
      total++; if (dbg_data !== exp_rd(5'(r), 1'b0)) begin bad++; $display("[TB] FAIL dbg_r%0d got=%h exp=%h", r, dbg_data, exp_rd(5'(r), 1'b0)); end
      tick();
    end
    set_idle();
    #1;
    total++; if (busy_count !== 6'd0) begin bad++; $display("[TB] FAIL drain_count got=%0d exp=0", busy_count); end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rd_addr1   = 5'($urandom_range(0, 31));
      rd_addr2   = 5'($urandom_range(0, 31));
      dbg_addr   = 5'($urandom_range(0, 31));
      wb_en      = 1'($urandom_range(0, 2) != 0);
      wb_addr    = (n % 4 == 0) ? rd_addr1 : 5'($urandom_range(0, 31));
      wb_data    = $urandom;
      alloc_en   = 1'($urandom_range(0, 1));
      alloc_addr = (n % 7 == 0) ? wb_addr : 5'($urandom_range(0, 31));
      #1;
      total++; if (rd_data1 !== exp_rd(rd_addr1, 1'b1)) begin bad++; $display("[TB] FAIL rnd_rd1 cyc=%0d got=%h exp=%h", n, rd_data1, exp_rd(rd_addr1, 1'b1)); end
      total++; if (rd_data2 !== exp_rd(rd_addr2, 1'b1)) begin bad++; $display("[TB] FAIL rnd_rd2 cyc=%0d got=%h exp=%h", n, rd_data2, exp_rd(rd_addr2, 1'b1)); end
      total++; if (rd_busy1 !== exp_bz(rd_addr1, 1'b1)) begin bad++; $display("[TB] FAIL rnd_busy1 cyc=%0d got=%b exp=%b", n, rd_busy1, exp_bz(rd_addr1, 1'b1)); end
      total++; if (rd_busy2 !== exp_bz(rd_addr2, 1'b1)) begin bad++; $display("[TB] FAIL rnd_busy2 cyc=%0d got=%b exp=%b", n, rd_busy2, exp_bz(rd_addr2, 1'b1)); end
      total++; if (dbg_data !== exp_rd(dbg_addr, 1'b0)) begin bad++; $display("[TB] FAIL rnd_dbg cyc=%0d got=%h exp=%h", n, dbg_data, exp_rd(dbg_addr, 1'b0)); end
      total++; if (busy_count !== exp_count()) begin bad++; $display("[TB] FAIL rnd_count cyc=%0d got=%0d exp=%0d", n, busy_count, exp_count()); end
      total++; if (nb_rd_data1 !== exp_rd(rd_addr1, 1'b0)) begin bad++; $display("[TB] FAIL rnd_nb_rd1 cyc=%0d got=%h exp=%h", n, nb_rd_data1, exp_rd(rd_addr1, 1'b0)); end
      total++; if (nb_rd_busy1 !== exp_bz(rd_addr1, 1'b0)) begin bad++; $display("[TB] FAIL rnd_nb_busy1 cyc=%0d got=%b exp=%b", n, nb_rd_busy1, exp_bz(rd_addr1, 1'b0)); end
      tick();
    end
    set_idle();
  endtask

  initial begin
    model_clear();
    $display("[TB] starting reg_file_sb bench");
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_collision();
    test_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
